peripheral_dbg_pu_riscv_cpu_responder: RTL and testbench



---
 rtl/peripheral_dbg_pu_riscv_cpu_responder.sv | 154 +++++++++++++++
 tb/tb_peripheral_dbg_pu_riscv_cpu_responder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_dbg_pu_riscv_cpu_responder.sv
// Per-core debug responder: debug registers, breakpoint/step halt; ack comes ACCESS_LAT+1 cycles after strobe.
// One access in flight, a held strobe waits for release; DBG_RESPONDER_HITCNT_EN adds the HITCNT counter.
module peripheral_dbg_pu_riscv_cpu_responder #(
  parameter int CPU_ADDR_WIDTH = 32,
  parameter int CPU_DATA_WIDTH = 32,
  parameter int NGPR           = 8,
  parameter int ACCESS_LAT     = 1
) (
  input  logic                      cpu_clk_i,
  input  logic                      cpu_rst_i,
  input  logic [CPU_ADDR_WIDTH-1:0] dbg_addr_i,
  input  logic [CPU_DATA_WIDTH-1:0] dbg_data_i,
  input  logic                      dbg_stb_i,
  input  logic                      dbg_we_i,
  input  logic                      dbg_stall_i,
  output logic [CPU_DATA_WIDTH-1:0] dbg_data_o,
  output logic                      dbg_ack_o,
  output logic                      dbg_bp_o,
  input  logic [CPU_ADDR_WIDTH-1:0] core_pc_i,
  input  logic                      core_valid_i,
  output logic                      core_stall_o
);

  localparam int GIDX_W = (NGPR > 1) ? $clog2(NGPR) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, ACK, WAIT} state_t;

  state_t                    state_q, state_d;
  logic [3:0]                cnt_q;
  logic [5:0]                addr_q;
  logic                      we_q;
  logic [CPU_DATA_WIDTH-1:0] wdata_q;
  logic [CPU_DATA_WIDTH-1:0] rdata_q;
  logic [CPU_DATA_WIDTH-1:0] rd_data;
  logic [CPU_DATA_WIDTH-1:0] hit_rd;
  logic                      step_q, bpen_q;
  logic [CPU_ADDR_WIDTH-1:0] dpc_q, bpaddr_q;
  logic [CPU_DATA_WIDTH-1:0] gpr_q [NGPR];
  logic                      bp_q, bp_d, stall_q;
  logic                      do_access, ack, wr_en, bp_match;
  logic [5:0]                goff;
  logic                      gpr_hit;
  logic [GIDX_W-1:0]         gidx;
  logic                      unused_addr;

  // Only the word offset within the low byte selects a register.
  assign unused_addr = ^{dbg_addr_i[CPU_ADDR_WIDTH-1:8], dbg_addr_i[1:0]};

  always_comb begin
    state_d   = state_q;
    ack       = 1'b0;
    do_access = 1'b0;
    case (state_q)
      IDLE:    if (dbg_stb_i) state_d = ACCESS;
      ACCESS:  if (cnt_q == 4'd0) begin
                 do_access = 1'b1;
                 state_d   = ACK;
               end
      ACK:     begin
                 ack     = 1'b1;
                 state_d = WAIT;
               end
      WAIT:    if (!dbg_stb_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign wr_en   = do_access && we_q;
  assign goff    = addr_q - 6'd4;
  assign gpr_hit = (addr_q >= 6'd4) && (goff < 6'(NGPR));
  assign gidx    = goff[GIDX_W-1:0];

  always_comb begin
    rd_data = '0;
    case (addr_q)
      6'd0:    rd_data[1:0] = {bpen_q, step_q};
      6'd1:    rd_data = CPU_DATA_WIDTH'(dpc_q);
      6'd2:    rd_data = CPU_DATA_WIDTH'(bpaddr_q);
      6'd3:    rd_data = hit_rd;
      default: if (gpr_hit) rd_data = gpr_q[gidx];
    endcase
  end

  always_ff @(posedge cpu_clk_i or posedge cpu_rst_i) begin
    if (cpu_rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && dbg_stb_i) begin
        addr_q  <= dbg_addr_i[7:2];
        we_q    <= dbg_we_i;
        wdata_q <= dbg_data_i;
        cnt_q   <= 4'(ACCESS_LAT - 1);
      end else if (state_q == ACCESS && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (do_access && !we_q) rdata_q <= rd_data;
    end
  end

  // Retires are ignored for matching while the core is frozen; a pending halt holds until the debugger stalls.
  assign bp_match = core_valid_i && !stall_q &&
                    ((bpen_q && core_pc_i == bpaddr_q) || (step_q && !dbg_stall_i));
  assign bp_d     = (bp_q && dbg_stall_i) ? 1'b0 : (bp_q | bp_match);

  always_ff @(posedge cpu_clk_i or posedge cpu_rst_i) begin
    if (cpu_rst_i) begin
      step_q   <= 1'b0;
      bpen_q   <= 1'b0;
      bpaddr_q <= '0;
      dpc_q    <= '0;
      bp_q     <= 1'b0;
      stall_q  <= 1'b0;
      for (int i = 0; i < NGPR; i++) gpr_q[i] <= '0;
    end else begin
      if (wr_en && addr_q == 6'd0) {bpen_q, step_q} <= wdata_q[1:0];
      if (wr_en && addr_q == 6'd2) bpaddr_q <= CPU_ADDR_WIDTH'(wdata_q);
      if (wr_en && gpr_hit) gpr_q[gidx] <= wdata_q;
      if (core_valid_i) dpc_q <= core_pc_i;
      bp_q    <= bp_d;
      stall_q <= dbg_stall_i | bp_q;
    end
  end

`ifdef DBG_RESPONDER_HITCNT_EN
  logic [CPU_DATA_WIDTH-1:0] hit_q;

  // A clearing write beats a same-cycle increment.
  always_ff @(posedge cpu_clk_i or posedge cpu_rst_i) begin
    if (cpu_rst_i) begin
      hit_q <= '0;
    end else if (wr_en && addr_q == 6'd3) begin
      hit_q <= '0;
    end else if (bp_d && !bp_q && !(&hit_q)) begin
      hit_q <= hit_q + 1'b1;
    end
  end

  assign hit_rd = hit_q;
`else
  assign hit_rd = '0;
`endif

  assign dbg_data_o   = rdata_q;
  assign dbg_ack_o    = ack;
  assign dbg_bp_o     = bp_q;
  assign core_stall_o = stall_q;

endmodule

// File: tb/tb_peripheral_dbg_pu_riscv_cpu_responder.sv
// Bench for the per-core debug responder: register-map model plus directed accesses, breakpoints and steps.
module tb_peripheral_dbg_pu_riscv_cpu_responder;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int NG  = 8;
  localparam int LAT = 3;
`ifdef DBG_RESPONDER_HITCNT_EN
  localparam bit HIT_EN = 1'b1;
`else
  localparam bit HIT_EN = 1'b0;
`endif

  logic          cpu_clk_i = 1'b0;
  logic          cpu_rst_i;
  logic [AW-1:0] addr, pc;
  logic [DW-1:0] wdat, rdat;
  logic          stb, we, dstall, valid;
  logic          ack, bp, cstall;

  int n_checks = 0;
  int n_fail   = 0;
  int bp_rises = 0;
  logic bp_prev = 1'b0;

  peripheral_dbg_pu_riscv_cpu_responder #(
    .CPU_ADDR_WIDTH(AW), .CPU_DATA_WIDTH(DW), .NGPR(NG), .ACCESS_LAT(LAT)
  ) dut (
    .cpu_clk_i   (cpu_clk_i),
    .cpu_rst_i   (cpu_rst_i),
    .dbg_addr_i  (addr),
    .dbg_data_i  (wdat),
    .dbg_stb_i   (stb),
    .dbg_we_i    (we),
    .dbg_stall_i (dstall),
    .dbg_data_o  (rdat),
    .dbg_ack_o   (ack),
    .dbg_bp_o    (bp),
    .core_pc_i   (pc),
    .core_valid_i(valid),
    .core_stall_o(cstall)
  );

  always #5 cpu_clk_i = ~cpu_clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          cyc = 0;
  int          m_phase, m_due;
  logic [31:0] m_a, m_wd;
  logic        m_we;
  logic        m_ack, m_bp, m_stall;
  logic [31:0] m_data;
  logic [1:0]  m_dcsr;
  logic [31:0] m_dpc, m_bpaddr, m_hit;
  logic [31:0] m_gpr [NG];
  logic        o_bp, o_stall, clr, ack_n, match;
  logic [1:0]  o_dcsr;
  logic [31:0] o_bpaddr;

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int b;
    b = int'(a[7:0]) & 'hFC;
    if (b == 'h00) return {30'b0, m_dcsr};
    if (b == 'h04) return m_dpc;
    if (b == 'h08) return m_bpaddr;
    if (b == 'h0C) return HIT_EN ? m_hit : 32'd0;
    if (b >= 'h10 && b < 'h10 + 4 * NG) return m_gpr[(b - 'h10) / 4];
    return 32'd0;
  endfunction

  task automatic m_write(input logic [31:0] a, input logic [31:0] d);
    int b;
    b = int'(a[7:0]) & 'hFC;
    if (b == 'h00) m_dcsr = d[1:0];
    else if (b == 'h08) m_bpaddr = d;
    else if (b >= 'h10 && b < 'h10 + 4 * NG) m_gpr[(b - 'h10) / 4] = d;
  endtask

  always @(posedge cpu_clk_i or posedge cpu_rst_i) begin
    if (cpu_rst_i) begin
      m_phase = 0; m_ack = 1'b0; m_bp = 1'b0; m_stall = 1'b0; m_data = '0;
      m_dcsr = '0; m_dpc = '0; m_bpaddr = '0; m_hit = '0;
      for (int i = 0; i < NG; i++) m_gpr[i] = '0;
    end else begin
      cyc      = cyc + 1;
      o_bp     = m_bp;
      o_stall  = m_stall;
      o_dcsr   = m_dcsr;
      o_bpaddr = m_bpaddr;
      clr      = 1'b0;
      ack_n    = 1'b0;
      case (m_phase)
        0: if (stb) begin
             m_a = addr; m_we = we; m_wd = wdat; m_due = cyc + LAT; m_phase = 1;
           end
        1: if (cyc == m_due) begin
             ack_n   = 1'b1;
             m_phase = 2;
             if (m_we) begin
               if ((m_a[7:0] & 8'hFC) == 8'h0C) clr = 1'b1;
               m_write(m_a, m_wd);
             end else begin
               m_data = m_read(m_a);
             end
           end
        default: if (!m_ack && !stb) m_phase = 0;
      endcase
      m_ack   = ack_n;
      match   = valid && !o_stall && ((o_dcsr[1] && pc == o_bpaddr) || (o_dcsr[0] && !dstall));
      m_bp    = o_bp ? !dstall : match;
      m_stall = dstall | o_bp;
      if (HIT_EN) begin
        if (clr) m_hit = '0;
        else if (m_bp && !o_bp && m_hit != 32'hFFFF_FFFF) m_hit = m_hit + 1;
      end
      if (valid) m_dpc = pc;
    end
  end

  always @(negedge cpu_clk_i) begin
    check("ack", {31'b0, ack}, {31'b0, m_ack});
    check("bp", {31'b0, bp}, {31'b0, m_bp});
    check("core_stall", {31'b0, cstall}, {31'b0, m_stall});
    check("data", rdat, m_data);
    if (bp && !bp_prev) bp_rises++;
    bp_prev = bp;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge cpu_clk_i);
    #1;
  endtask

  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d, input int hold,
                        output logic [31:0] rd, output int lat, output int extra);
    lat = 0; extra = 0;
    addr = a; wdat = d; we = w; stb = 1'b1;
    do begin
      tick();
      lat++;
    end while (!ack && lat < 50);
    check("ack_seen", {31'b0, ack}, 32'd1);
    rd = rdat;
    repeat (hold) begin tick(); if (ack) extra++; end
    stb = 1'b0;
    repeat (2) begin tick(); if (ack) extra++; end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    int l, e;
    access(1'b1, a, d, 0, r, l, e);
    check("wr_lat", l, LAT + 1);
    check("wr_extra_ack", e, 0);
  endtask

  task automatic rdchk(input string nm, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    int l, e;
    access(1'b0, a, '0, 0, r, l, e);
    check(nm, r, exp);
    check("rd_lat", l, LAT + 1);
  endtask

  initial begin
    logic [31:0] r;
    int l, e, rises0;
    cpu_rst_i = 1'b1;
    addr = '0; wdat = '0; stb = 1'b0; we = 1'b0; dstall = 1'b0; pc = '0; valid = 1'b0;
    repeat (3) tick();
    check("rst_data", rdat, 0);
    check("rst_ack", {31'b0, ack}, 0);
    check("rst_bp", {31'b0, bp}, 0);
    check("rst_stall", {31'b0, cstall}, 0);
    cpu_rst_i = 1'b0;
    tick();

    access(1'b1, 32'h14, 32'hDEADBEEF, 0, r, l, e);
    check("wr14_lat", l, 4);
    check("wr14_ack_width", e, 0);
    access(1'b0, 32'h14, 32'h0, 0, r, l, e);
    check("rd14_lat", l, 4);
    check("rd14_data", r, 32'hDEADBEEF);

    access(1'b0, 32'h14, 32'h0, 10, r, l, e);
    check("held_stb_extra_acks", e, 0);
    wr(32'h18, 32'h12345678);
    rdchk("rd18", 32'h18, 32'h12345678);
    rdchk("rd_dcsr_reset", 32'h00, 32'h0);

    wr(32'h08, 32'h100);
    wr(32'h00, 32'h2);
    rdchk("rd_dcsr", 32'h00, 32'h2);
    valid = 1'b1; pc = 32'hFC;
    tick();
    check("bp_after_fc", {31'b0, bp}, 0);
    pc = 32'h100;
    tick();
    valid = 1'b0;
    check("bp_after_100", {31'b0, bp}, 1);
    check("stall_not_yet", {31'b0, cstall}, 0);
    tick();
    check("stall_follows", {31'b0, cstall}, 1);
    rdchk("rd_dpc", 32'h04, 32'h100);
    check("bp_held", {31'b0, bp}, 1);

    dstall = 1'b1;
    tick();
    check("bp_cleared", {31'b0, bp}, 0);
    check("stall_kept", {31'b0, cstall}, 1);
    repeat (3) tick();
    check("stall_kept2", {31'b0, cstall}, 1);
    rdchk("hit_after_bp", 32'h0C, HIT_EN ? 32'd1 : 32'd0);
    wr(32'h0C, 32'h0);
    rdchk("hit_cleared", 32'h0C, 32'h0);
    wr(32'h00, 32'h1);
    dstall = 1'b0;
    tick();
    check("stall_released", {31'b0, cstall}, 0);
    rises0 = bp_rises;
    valid = 1'b1; pc = 32'h200;
    tick();
    check("step_bp", {31'b0, bp}, 1);
    pc = 32'h204;
    tick();
    valid = 1'b0;
    repeat (2) tick();
    check("step_single_rise", bp_rises - rises0, 1);
    rdchk("step_dpc", 32'h04, 32'h204);
    dstall = 1'b1;
    tick();
    check("step_bp_cleared", {31'b0, bp}, 0);
    wr(32'h00, 32'h0);
    rdchk("hit_after_step", 32'h0C, HIT_EN ? 32'd1 : 32'd0);
    dstall = 1'b0;
    repeat (2) tick();

    rdchk("rd_unmapped", 32'h80, 32'h0);
    wr(32'h80, 32'h55);
    rdchk("rd_unmapped_after_wr", 32'h80, 32'h0);
    rdchk("rd_low_bits_ignored", 32'h16, 32'hDEADBEEF);
    wr(32'h04, 32'h999);
    rdchk("dpc_read_only", 32'h04, 32'h204);

    dstall = 1'b1;
    repeat (2) tick();
    addr = 32'h14; we = 1'b0; stb = 1'b1;
    repeat (2) tick();
    #2;
    cpu_rst_i = 1'b1;
    dstall = 1'b0;
    #1;
    check("midrst_data", rdat, 0);
    check("midrst_ack", {31'b0, ack}, 0);
    check("midrst_bp", {31'b0, bp}, 0);
    check("midrst_stall", {31'b0, cstall}, 0);
    tick();
    stb = 1'b0;
    tick();
    cpu_rst_i = 1'b0;
    repeat (3) tick();
    check("no_ack_after_rst", {31'b0, ack}, 0);
    rdchk("gpr14_cleared", 32'h14, 32'h0);
    rdchk("gpr18_cleared", 32'h18, 32'h0);
    rdchk("bpaddr_cleared", 32'h08, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
